// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, control FSM states and the
// ALU/memory opcode decode used by both the control unit and the datapath.
package cpu_pkg;

    localparam int unsigned OP_HLT = 0;
    localparam int unsigned OP_SKZ = 1;
    localparam int unsigned OP_ADD = 2;
    localparam int unsigned OP_AND = 3;
    localparam int unsigned OP_XOR = 4;
    localparam int unsigned OP_LDA = 5;
    localparam int unsigned OP_STO = 6;
    localparam int unsigned OP_JMP = 7;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_e;

    // Opcodes that read an operand from memory into the accumulator.
    function automatic logic is_aluop(input int unsigned op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    // Opcodes that perform a data memory access.
    function automatic logic is_memop(input int unsigned op);
        return is_aluop(op) || (op == OP_STO);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Loadable saturating up-counter of consecutive memory stall cycles; flags
// when the next stalled cycle would reach LIMIT (LIMIT of 0 never expires).
module wait_timer #(
    parameter int unsigned W     = 5,
    parameter int unsigned LIMIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (LIMIT != 0) && (cnt >= W'(LIMIT - 1));

endmodule

// File: rtl/control_unit_hs.sv
// RISC control unit with mem_ready wait states, resumable halt, bus timeout
// and a retired-instruction counter.
module control_unit_hs
    import cpu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                is_zero,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                wr,
    output logic                data_e,
    output logic                bus_err,
    output logic [STATE_W-1:0]  state,
    output logic [CNT_W-1:0]    instr_cnt
);

    localparam int unsigned TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [31:0] op_c;
    logic        aluop_c, memop_c, hlt_c, skz_c, sto_c, jmp_c;
    logic        stall_c, timeout_c, expired;
    logic        sel_d, rd_d, ld_ir_d, halt_d, inc_pc_d, ld_ac_d, ld_pc_d, wr_d, data_e_d;
    logic        ld_ac_q;

    assign op_c    = 32'(opcode);
    assign aluop_c = is_aluop(op_c);
    assign memop_c = is_memop(op_c);
    assign hlt_c   = (op_c == OP_HLT);
    assign skz_c   = (op_c == OP_SKZ);
    assign sto_c   = (op_c == OP_STO);
    assign jmp_c   = (op_c == OP_JMP);

    wait_timer #(
        .W     (TW),
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (!stall_c),
        .load     (1'b0),
        .load_val ('0),
        .en       (stall_c),
        .expired  (expired)
    );

    // Next state, then strobes decoded from the next state so they register in step with it.
    always_comb begin
        state_d   = state_q;
        stall_c   = 1'b0;
        timeout_c = 1'b0;
        sel_d     = 1'b0;
        rd_d      = 1'b0;
        ld_ir_d   = 1'b0;
        halt_d    = 1'b0;
        inc_pc_d  = 1'b0;
        ld_ac_d   = 1'b0;
        ld_pc_d   = 1'b0;
        wr_d      = 1'b0;
        data_e_d  = 1'b0;

        case (state_q)
            S_INST_ADDR:  state_d = S_INST_FETCH;
            S_INST_FETCH: begin
                if (mem_ready) state_d = S_INST_LOAD;
                else           stall_c = 1'b1;
            end
            S_INST_LOAD:  state_d = S_IDLE;
            S_IDLE:       state_d = S_OP_ADDR;
            S_OP_ADDR:    state_d = hlt_c ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH: begin
                if (memop_c && !mem_ready) stall_c = 1'b1;
                else                       state_d = S_ALU_OP;
            end
            S_ALU_OP:     state_d = S_STORE;
            S_STORE: begin
                if (memop_c && !mem_ready) stall_c = 1'b1;
                else                       state_d = S_INST_ADDR;
            end
            S_HALTED: begin
                if (resume && !bus_err) state_d = S_INST_ADDR;
            end
            default:      state_d = S_INST_ADDR;
        endcase

        if (stall_c && expired) begin
            state_d   = S_HALTED;
            timeout_c = 1'b1;
        end

        sel_d    = state_d inside {S_INST_ADDR, S_INST_FETCH, S_INST_LOAD, S_IDLE};
        rd_d     = (state_d inside {S_INST_FETCH, S_INST_LOAD, S_IDLE})
                 || (aluop_c && (state_d inside {S_OP_FETCH, S_ALU_OP, S_STORE}));
        ld_ir_d  = state_d inside {S_INST_LOAD, S_IDLE};
        halt_d   = (state_d == S_HALTED);
        inc_pc_d = (state_d == S_OP_ADDR) || (skz_c && is_zero && (state_d == S_ALU_OP));
        ld_ac_d  = aluop_c && (state_d == S_STORE);
        ld_pc_d  = jmp_c && (state_d inside {S_ALU_OP, S_STORE});
        wr_d     = sto_c && (state_d == S_STORE);
        data_e_d = sto_c && (state_d inside {S_ALU_OP, S_STORE});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_INST_ADDR;
            sel       <= 1'b1;
            rd        <= 1'b0;
            ld_ir     <= 1'b0;
            halt      <= 1'b0;
            inc_pc    <= 1'b0;
            ld_ac_q   <= 1'b0;
            ld_pc     <= 1'b0;
            wr        <= 1'b0;
            data_e    <= 1'b0;
            bus_err   <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            sel     <= sel_d;
            rd      <= rd_d;
            ld_ir   <= ld_ir_d;
            halt    <= halt_d;
            inc_pc  <= inc_pc_d;
            ld_ac_q <= ld_ac_d;
            ld_pc   <= ld_pc_d;
            wr      <= wr_d;
            data_e  <= data_e_d;
            if (timeout_c) bus_err <= 1'b1;
            if ((state_q == S_STORE) && (state_d == S_INST_ADDR)) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    // Accumulator load fires on the cycle the operand read completes.
    assign ld_ac = ld_ac_q & mem_ready;
    assign state = state_q;

endmodule

// File: tb/tb_control_unit_hs.sv
// Randomized self-checking bench for control_unit_hs; expected state and
// strobes per cycle come from an instruction-level phase list built from the rules.
module tb_control_unit_hs;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned TIMEOUT  = 4;
    localparam int unsigned CNT_W    = 4;
    localparam logic [8:0]  SB_RESET = 9'b1_0000_0000;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [OPCODE_W-1:0] opcode = '0;
    logic                is_zero = 1'b0;
    logic                mem_ready = 1'b0;
    logic                resume = 1'b0;
    logic sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, bus_err;
    logic [3:0]          state;
    logic [CNT_W-1:0]    instr_cnt;

    always #5 clk = ~clk;

    control_unit_hs #(.OPCODE_W(OPCODE_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .is_zero(is_zero),
        .mem_ready(mem_ready), .resume(resume),
        .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc),
        .ld_ac(ld_ac), .ld_pc(ld_pc), .wr(wr), .data_e(data_e),
        .bus_err(bus_err), .state(state), .instr_cnt(instr_cnt)
    );

    typedef struct { int st; bit mr; bit rs; } cyc_t;

    cyc_t             tr[$];
    logic [3:0]       obs_st[$];
    logic [8:0]       obs_sb[$];
    logic             obs_be[$];
    logic [3:0]       end_st;
    logic             end_be;
    logic [CNT_W-1:0] end_cnt;
    int passed = 0;
    int total = 0;
    int cnt_model = 0;
    bit be_model = 1'b0;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit dc(input bit tie);
        return tie ? 1'b1 : rb();
    endfunction

    function automatic bit is_alu(input int op);
        return (op >= 2) && (op <= 5);
    endfunction

    // Strobe vector {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e} from the output equations.
    function automatic logic [8:0] exp_sb(input int st, input int op, input bit iz, input bit mr);
        logic [8:0] s;
        s[8] = (st <= 3);
        s[7] = (st >= 1 && st <= 3) || (st >= 5 && st <= 7 && is_alu(op));
        s[6] = (st == 2) || (st == 3);
        s[5] = (st == 8);
        s[4] = (st == 4) || (st == 6 && op == 1 && iz);
        s[3] = (st == 7) && is_alu(op) && mr;
        s[2] = (op == 7) && (st == 6 || st == 7);
        s[1] = (op == 6) && (st == 7);
        s[0] = (op == 6) && (st == 6 || st == 7);
        return s;
    endfunction

    task automatic push(input int st, input bit mr, input bit rs);
        cyc_t c;
        c.st = st; c.mr = mr; c.rs = rs;
        tr.push_back(c);
    endtask

    // Phase list of one instruction: kf/ko/ks stalls at the fetch/operand/store waits, kh halted cycles.
    task automatic build(input int op, input int kf, input int ko, input int ks, input int kh, input bit tie);
        bit memop;
        memop = is_alu(op) || (op == 6);
        tr.delete();
        push(0, dc(tie), rb());
        repeat (kf) push(1, 1'b0, rb());
        push(1, 1'b1, rb());
        push(2, dc(tie), rb());
        push(3, dc(tie), rb());
        push(4, dc(tie), rb());
        if (op == 0) begin
            repeat (kh) push(8, dc(tie), 1'b0);
            push(8, dc(tie), 1'b1);
            return;
        end
        if (memop) begin
            repeat (ko) push(5, 1'b0, rb());
            push(5, 1'b1, rb());
        end else push(5, dc(tie), rb());
        push(6, dc(tie), rb());
        if (memop) begin
            repeat (ks) push(7, 1'b0, rb());
            push(7, 1'b1, rb());
        end else push(7, dc(tie), rb());
        if (op != 0) cnt_model = (cnt_model + 1) % (1 << CNT_W);
    endtask

    // Drives the phase list one cycle at a time starting in clk-low, capturing outputs mid-cycle.
    task automatic play(input int op, input bit iz);
        opcode = OPCODE_W'(op);
        is_zero = iz;
        obs_st.delete(); obs_sb.delete(); obs_be.delete();
        foreach (tr[i]) begin
            mem_ready = tr[i].mr;
            resume = tr[i].rs;
            #1;
            obs_st.push_back(state);
            obs_sb.push_back({sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e});
            obs_be.push_back(bus_err);
            @(negedge clk);
        end
        resume = 1'b0;
        #1;
        end_st = state; end_be = bus_err; end_cnt = instr_cnt;
    endtask

    task automatic test_reset();
        resume = 1'b1;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (state !== 4'd0 || {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e} !== SB_RESET
            || bus_err !== 1'b0 || instr_cnt !== '0)
            $display("FAIL reset: state=%0d strobes=%b bus_err=%b cnt=%0d, required 0 %b 0 0",
                     state, {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}, bus_err, instr_cnt, SB_RESET);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        resume = 1'b0;
    endtask

    task automatic test_legacy();
        for (int op = 0; op < 8; op++) begin
            for (int z = 0; z < 2; z++) begin
                build(op, 0, 0, 0, 1, 1'b1);
                play(op, 1'(z));
                foreach (tr[i]) begin
                    total++;
                    if (obs_st[i] !== 4'(tr[i].st) || obs_sb[i] !== exp_sb(tr[i].st, op, 1'(z), tr[i].mr) || obs_be[i] !== be_model)
                        $display("FAIL legacy op=%0d z=%0d cyc=%0d: state=%0d strobes=%b err=%b, required %0d %b %b", op, z, i,
                                 obs_st[i], obs_sb[i], obs_be[i], tr[i].st, exp_sb(tr[i].st, op, 1'(z), tr[i].mr), be_model);
                    else passed++;
                end
                total++;
                if (end_st !== 4'd0 || end_cnt !== CNT_W'(cnt_model))
                    $display("FAIL legacy_end op=%0d: state=%0d cnt=%0d, required 0 %0d", op, end_st, end_cnt, cnt_model);
                else passed++;
            end
        end
    endtask

    task automatic test_fetch_stall();
        int n_ld;
        build(2, 3, 0, 0, 0, 1'b0);
        play(2, rb());
        n_ld = 0;
        foreach (tr[i]) begin
            total++;
            if (obs_st[i] !== 4'(tr[i].st) || obs_sb[i] !== exp_sb(tr[i].st, 2, is_zero, tr[i].mr) || obs_be[i] !== be_model)
                $display("FAIL fetch_stall cyc=%0d: state=%0d strobes=%b, required %0d %b", i,
                         obs_st[i], obs_sb[i], tr[i].st, exp_sb(tr[i].st, 2, is_zero, tr[i].mr));
            else passed++;
            n_ld += int'(obs_sb[i][3]);
        end
        total++;
        if (n_ld !== 1 || end_st !== 4'd0 || end_cnt !== CNT_W'(cnt_model))
            $display("FAIL fetch_stall_end: ld_ac pulses=%0d state=%0d cnt=%0d, required 1 0 %0d", n_ld, end_st, end_cnt, cnt_model);
        else passed++;
    endtask

    task automatic test_sto_wait();
        int n_wr, n_ld;
        build(6, 0, 0, 2, 0, 1'b0);
        play(6, rb());
        n_wr = 0; n_ld = 0;
        foreach (tr[i]) begin
            total++;
            if (obs_st[i] !== 4'(tr[i].st) || obs_sb[i] !== exp_sb(tr[i].st, 6, is_zero, tr[i].mr))
                $display("FAIL sto_wait cyc=%0d: state=%0d strobes=%b, required %0d %b", i,
                         obs_st[i], obs_sb[i], tr[i].st, exp_sb(tr[i].st, 6, is_zero, tr[i].mr));
            else passed++;
            n_wr += int'(obs_sb[i][1] & obs_sb[i][0]);
            n_ld += int'(obs_sb[i][3]);
        end
        total++;
        if (n_wr !== 3 || n_ld !== 0 || end_cnt !== CNT_W'(cnt_model))
            $display("FAIL sto_wait_end: wr&data_e cycles=%0d ld_ac=%0d cnt=%0d, required 3 0 %0d", n_wr, n_ld, end_cnt, cnt_model);
        else passed++;
    endtask

    task automatic test_halt_resume();
        int first;
        build(0, 0, 0, 0, 3, 1'b0);
        play(0, rb());
        first = -1;
        foreach (tr[i]) begin
            total++;
            if (obs_st[i] !== 4'(tr[i].st) || obs_sb[i] !== exp_sb(tr[i].st, 0, is_zero, tr[i].mr))
                $display("FAIL halt cyc=%0d: state=%0d strobes=%b, required %0d %b", i,
                         obs_st[i], obs_sb[i], tr[i].st, exp_sb(tr[i].st, 0, is_zero, tr[i].mr));
            else passed++;
            if (first < 0 && obs_sb[i][5]) first = i;
        end
        total++;
        if (first !== 5 || end_st !== 4'd0 || end_cnt !== CNT_W'(cnt_model))
            $display("FAIL halt_end: first halt cyc=%0d state=%0d cnt=%0d, required 5 0 %0d", first, end_st, end_cnt, cnt_model);
        else passed++;
    endtask

    task automatic test_random();
        int op;
        bit z;
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 15));
            z = rb();
            build(op, int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, TIMEOUT - 1)),
                  int'($urandom_range(0, TIMEOUT - 1)), int'($urandom_range(0, 3)), 1'b0);
            play(op, z);
            foreach (tr[i]) begin
                total++;
                if (obs_st[i] !== 4'(tr[i].st) || obs_sb[i] !== exp_sb(tr[i].st, op, z, tr[i].mr) || obs_be[i] !== be_model)
                    $display("FAIL random n=%0d op=%0d cyc=%0d: state=%0d strobes=%b err=%b, required %0d %b %b", n, op, i,
                             obs_st[i], obs_sb[i], obs_be[i], tr[i].st, exp_sb(tr[i].st, op, z, tr[i].mr), be_model);
                else passed++;
            end
            total++;
            if (end_st !== 4'd0 || end_cnt !== CNT_W'(cnt_model))
                $display("FAIL random_end n=%0d: state=%0d cnt=%0d, required 0 %0d", n, end_st, end_cnt, cnt_model);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        tr.delete();
        push(0, 1'b1, 1'b0); push(1, 1'b1, 1'b0); push(2, rb(), 1'b0); push(3, rb(), 1'b0); push(4, rb(), 1'b0);
        repeat (TIMEOUT) push(5, 1'b0, rb());
        play(5, rb());
        foreach (tr[i]) begin
            total++;
            if (obs_st[i] !== 4'(tr[i].st) || obs_sb[i] !== exp_sb(tr[i].st, 5, is_zero, tr[i].mr) || obs_be[i] !== 1'b0)
                $display("FAIL timeout cyc=%0d: state=%0d strobes=%b err=%b, required %0d %b 0", i,
                         obs_st[i], obs_sb[i], obs_be[i], tr[i].st, exp_sb(tr[i].st, 5, is_zero, tr[i].mr));
            else passed++;
        end
        total++;
        if (end_st !== 4'd8 || end_be !== 1'b1 || halt !== 1'b1)
            $display("FAIL timeout_end: state=%0d bus_err=%b halt=%b, required 8 1 1", end_st, end_be, halt);
        else passed++;
        be_model = 1'b1;
        tr.delete();
        repeat (3) push(8, rb(), 1'b1);
        play(5, is_zero);
        foreach (tr[i]) begin
            total++;
            if (obs_st[i] !== 4'd8 || obs_sb[i] !== exp_sb(8, 5, is_zero, tr[i].mr) || obs_be[i] !== be_model)
                $display("FAIL timeout_resume cyc=%0d: state=%0d strobes=%b err=%b, required 8 %b 1", i,
                         obs_st[i], obs_sb[i], obs_be[i], exp_sb(8, 5, is_zero, tr[i].mr));
            else passed++;
        end
    endtask

    task automatic test_reset_mid_op();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || bus_err !== 1'b0 || halt !== 1'b0)
            $display("FAIL reset_halted: state=%0d bus_err=%b halt=%b, required 0 0 0", state, bus_err, halt);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        be_model = 1'b0;
        cnt_model = 0;
        tr.delete();
        push(0, rb(), 1'b0); push(1, 1'b1, 1'b0); push(2, rb(), 1'b0); push(3, rb(), 1'b0);
        push(4, rb(), 1'b0); push(5, 1'b1, 1'b0); push(6, rb(), 1'b0); push(7, 1'b0, 1'b0);
        play(2, rb());
        foreach (tr[i]) begin
            total++;
            if (obs_st[i] !== 4'(tr[i].st) || obs_sb[i] !== exp_sb(tr[i].st, 2, is_zero, tr[i].mr) || obs_be[i] !== be_model)
                $display("FAIL reset_mid_op cyc=%0d: state=%0d strobes=%b, required %0d %b", i,
                         obs_st[i], obs_sb[i], tr[i].st, exp_sb(tr[i].st, 2, is_zero, tr[i].mr));
            else passed++;
        end
        total++;
        if (end_st !== 4'd7)
            $display("FAIL reset_mid_op_store: state=%0d, required 7", end_st);
        else passed++;
        mem_ready = 1'b1;
        resume = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e} !== SB_RESET
            || bus_err !== 1'b0 || instr_cnt !== '0)
            $display("FAIL reset_mid_op_async: state=%0d strobes=%b bus_err=%b cnt=%0d, required 0 %b 0 0",
                     state, {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e}, bus_err, instr_cnt, SB_RESET);
        else passed++;
        @(negedge clk);
        resume = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_fetch_stall();
        test_sto_wait();
        test_halt_resume();
        test_random();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/control_unit_hs.md
# control_unit_hs

Parametrised successor to the 8-state RISC control unit. It keeps the same fetch/decode/execute sequence and control strobes, and adds four things: a memory `mem_ready` wait-state handshake, a re-enterable HALTED state released by `resume`, a bus timeout with a sticky error flag, and a retired-instruction counter. It sits between the instruction register/accumulator zero flag and the datapath and memory strobes of the CPU. With `mem_ready` tied high it is cycle-identical to the legacy unit.

## Interface
Parameters:
- `OPCODE_W`, default 3: opcode width, minimum 3. Codes 8 and above decode as NOP.
- `TIMEOUT`, default 16: maximum cycles spent waiting on `mem_ready`. A value of 0 disables the timeout.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `opcode`  in  OPCODE_W  current IR opcode. Encodings: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
- `is_zero`  in  1  accumulator-zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `resume`  in  1  single-cycle request to leave HALTED.
- `sel`, `rd`, `ld_ir`, `halt`, `inc_pc`, `ld_ac`, `ld_pc`, `wr`, `data_e`  out  1 each  datapath and memory strobes.
- `bus_err`  out  1  sticky memory timeout flag.
- `state`  out  4  current state encoding, for debug.
- `instr_cnt`  out  CNT_W  retired-instruction count; wraps around.

## Operation
Decode terms:
- ALUOP = ADD | AND | XOR | LDA.
- MEMOP = ALUOP | STO.

States and encodings: INST_ADDR 0, INST_FETCH 1, INST_LOAD 2, IDLE 3, OP_ADDR 4, OP_FETCH 5, ALU_OP 6, STORE 7, HALTED 8.

Output equations (a strobe is 0 in any state not listed for it):
- `sel` = 1 in states 0–3.
- `rd` = 1 in INST_FETCH, INST_LOAD and IDLE. It is also 1 in OP_FETCH, ALU_OP and STORE when ALUOP.
- `ld_ir` = 1 in INST_LOAD and IDLE.
- `inc_pc` = 1 in OP_ADDR. It is also 1 in ALU_OP when SKZ & `is_zero`.
- `ld_pc` = JMP, in ALU_OP and STORE.
- `data_e` = STO, in ALU_OP and STORE.
- `wr` = STO, in STORE.
- `ld_ac` = ALUOP & `mem_ready`, in STORE. It is a single pulse.
- `halt` = 1 only in HALTED.

Transitions:
- The sequence 0→1→2→3→4→5→6→7→0 advances one state per cycle, except at the wait states.
- Wait states and their advance conditions:
  - INST_FETCH always waits for `mem_ready`.
  - OP_FETCH waits only when MEMOP.
  - STORE waits only when MEMOP.
- A wait state advances only on a cycle with `mem_ready`=1. Its outputs hold while it stalls.
- OP_ADDR with HLT goes to HALTED, not OP_FETCH. PC has already been incremented, so `resume` fetches the next instruction.
- HALTED goes to INST_ADDR on `resume`=1 with `bus_err`=0. `resume` is ignored in every other state, and whenever `bus_err`=1.
- Leaving STORE increments `instr_cnt`. HLT is not counted.

Timeout:
- A wait counter counts consecutive stalled cycles and clears on leaving a wait state.
- When the counter reaches TIMEOUT (TIMEOUT>0), the next state is HALTED and `bus_err` is set to 1.
- `bus_err` clears only on reset.

## Timing
- Reset values: state INST_ADDR, so `sel`=1 and all other strobes 0. `bus_err`=0, `instr_cnt`=0, wait counter 0.
- Reset asserted mid-instruction returns the FSM to INST_ADDR immediately. Reset wins over `resume`.
- With no stalls, each instruction takes 8 cycles. Each stalled cycle adds one cycle.
- `mem_ready` is sampled only in wait states. In other states it is ignored.
- Stall and timeout boundaries:
  - With `mem_ready`=0 for exactly TIMEOUT−1 cycles followed by 1, the FSM advances normally.
  - With TIMEOUT stalled cycles, HALTED is entered on the next edge.
- `opcode` and `is_zero` must be stable from OP_ADDR through STORE. The block does not latch them.
- All outputs are Moore-registered from state, except the `mem_ready` term of `ld_ac`.
- `instr_cnt` wraps from 2^CNT_W−1 to 0.

## Structure
- Shared package `cpu_pkg` holds:
  - the opcode localparams;
  - the state enum typedef (4-bit);
  - the ALUOP/MEMOP decode functions, which are reused by the datapath.
- Sub-module `wait_timer`: a loadable saturating counter with a `clear` input and an `expired` output.
- The FSM and output decode stay in `control_unit_hs`.

## Test plan
- **Legacy equivalence:** `mem_ready`=1, sweep opcodes 0–7 with `is_zero` 0 and 1. Each instruction is 8 cycles, and the strobes match the equations. For SKZ with `is_zero`=1, `inc_pc`=1 in ALU_OP.
- **Fetch stall:** ADD, `mem_ready`=0 for 3 cycles in INST_FETCH. Expect 11 cycles total, `rd` held, exactly one `ld_ac` pulse, and `instr_cnt` +1.
- **STO write wait:** STO, 2 stalled cycles in STORE. Expect `wr`=`data_e`=1 for 3 cycles and `ld_ac`=0.
- **Halt/resume:** HLT. Expect `halt`=1 from cycle 5 onward and `instr_cnt` unchanged. `resume` pulse → INST_ADDR on the next cycle.
- **Timeout:** TIMEOUT=4, `mem_ready`=0 held in OP_FETCH (LDA). After 4 stalled cycles, HALTED with `bus_err`=1. `resume` is ignored until reset.
- **Reset mid-op:** assert `rst`=0 during STORE. The FSM enters INST_ADDR asynchronously, `bus_err`=0 and `instr_cnt`=0.
